mips_multicycle_controller: RTL and testbench
=============================================

# mips_multicycle_controller

Control unit for the multicycle MIPS core. It decodes the instruction register opcode and funct fields. A Moore state machine sequences the shared datapath (single memory, single ALU, instruction/data registers) through fetch, decode, execute, memory and writeback. A memory-ready handshake stalls the sequence on slow memory. It replaces the single-cycle combinational controller and sits beside the datapath inside `top`.

## Interface
Parameters:
- none; all encodings are fixed constants from the shared package.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high; forces state to FETCH
- `op`  in  6  instr[31:26] from instruction register
- `funct`  in  6  instr[5:0]
- `zero`  in  1  ALU zero flag
- `memready`  in  1  memory access completes this cycle
- `memwrite`  out  1  store strobe
- `irwrite`  out  1  load instruction register
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `regdst`  out  1  write register select: 0 = rt, 1 = rd
- `memtoreg`  out  1  writeback select: 0 = ALUOut, 1 = Data
- `regwrite`  out  1  register file write
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = A
- `alusrcb`  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- `pcsrc`  out  2  PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- `pcen`  out  1  PC write enable
- `alucontrol`  out  3  ALU operation
- `illegal_op`  out  1  one-cycle pulse in DECODE on an unsupported opcode

## Operation
- States and transitions:
  - FETCH→DECODE when `memready`=1; otherwise stays in FETCH.
  - DECODE, by opcode:
    - lw/sw (100011/101011) → MEMADR
    - R-type (000000) → RTYPEEX
    - beq (000100) → BEQEX
    - addi (001000) → ADDIEX
    - j (000010) → JEX
    - any other opcode → FETCH with `illegal_op`=1
  - MEMADR→MEMRD for lw, →MEMWR for sw.
  - MEMRD→MEMWB when `memready`=1, else stays.
  - MEMWR→FETCH when `memready`=1, else stays.
  - RTYPEEX→RTYPEWB; ADDIEX→ADDIWB.
  - MEMWB, RTYPEWB, ADDIWB, BEQEX and JEX → FETCH.
- Outputs are Moore decodes of state. Exceptions: `pcen`, `irwrite` and `memwrite` are qualified by inputs as noted.
- Per-state assertions (everything not listed is 0):
  - FETCH: `alusrcb`=01, aluop=ADD, `irwrite`=`memready`, pcwrite=`memready`
  - DECODE: `alusrcb`=11, aluop=ADD
  - MEMADR and ADDIEX: `alusrca`=1, `alusrcb`=10, aluop=ADD
  - MEMRD: `iord`=1
  - MEMWB: `regwrite`=1, `memtoreg`=1
  - MEMWR: `iord`=1, `memwrite`=1 held until `memready`
  - RTYPEEX: `alusrca`=1, aluop=FUNCT
  - RTYPEWB: `regdst`=1, `regwrite`=1
  - ADDIWB: `regwrite`=1
  - BEQEX: `alusrca`=1, aluop=SUB, `pcsrc`=01, branch=1
  - JEX: `pcsrc`=10, pcwrite=1
- `pcen` = pcwrite | (branch & `zero`).
- ALU decode:
  - aluop ADD → 010; SUB → 110.
  - aluop FUNCT: 100000→010 (add), 100010→110 (sub), 100100→000 (and), 100101→001 (or), 101010→111 (slt), any other funct→010.

## Timing
- Reset: state=FETCH immediately (asynchronous). All outputs take FETCH values. `irwrite`/`pcen` follow `memready`; `alusrcb`=01; `alucontrol`=010; `illegal_op`=0.
- Cycles per instruction with `memready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle with `memready`=0 in FETCH, MEMRD or MEMWR adds one cycle. While stalled, no write strobe other than `memwrite` (in MEMWR) is asserted.
- `op` and `funct` are sampled only in DECODE and later states. The datapath holds the instruction register stable after FETCH.
- Reset asserted mid-instruction aborts it at once. No further `regwrite`/`memwrite` is issued for that instruction.

## Structure
- Package `mips_pkg`:
  - opcode and funct constants
  - state enum (4-bit)
  - aluop enum {ADD, SUB, FUNCT}
  - alucontrol constants
- Sub-module `alu_decoder`: purely combinational aluop+funct→`alucontrol`. The top level holds the state register, next-state logic and output decode.

## Test plan
- Reset released with `memready`=1, op=100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `regwrite`=1 and `memtoreg`=1 in cycle 5 only.
- sw (101011) with `memready` low for 2 cycles in MEMWR → `memwrite`=1 for exactly 3 cycles, `iord`=1, then FETCH.
- R-type, funct=101010 → `alucontrol`=111 in RTYPEEX; `regdst`=1 and `regwrite`=1 next cycle. Repeat for 100010 (expect 110) and an unknown funct (expect 010).
- beq with `zero`=1 → `pcen`=1, `pcsrc`=01 in BEQEX. With `zero`=0 → `pcen`=0. Both take 3 cycles.
- op=111111 → `illegal_op` pulses 1 cycle in DECODE, next state FETCH, no writes.
- `reset` asserted during MEMWR between clock edges → `memwrite` drops immediately. After release, FETCH outputs appear.

Source files
------------

// File: rtl/mips_multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, ALU codes, FSM states.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD = 2'd0, ALUOP_SUB = 2'd1, ALUOP_FUNCT = 2'd2} aluop_t;

    // Per-state control word. irwrite_mr/pcwrite_mr are the FETCH strobes that
    // only take effect once memory reports the fetch complete.
    typedef struct packed {
        logic       memwrite;
        logic       irwrite_mr;
        logic       pcwrite_mr;
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        aluop_t     aluop;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.alusrcb = 2'b01; c.irwrite_mr = 1'b1; c.pcwrite_mr = 1'b1; end
            S_DECODE:  c.alusrcb = 2'b11;
            S_MEMADR,
            S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
            S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
            S_RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            S_ADDIWB:  c.regwrite = 1'b1;
            S_BEQEX:   begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
            S_JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default:   ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and status in, datapath strobes/selects out.
// Latency: n/a (wiring only).
// Backpressure: memready stalls the controller in FETCH, MEMRD and MEMWR.
interface mips_multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       memwrite;
    logic       irwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       illegal_op;

    // master: datapath side, slave: controller side
    modport master (
        output op, funct, zero, memready,
        input  memwrite, irwrite, iord, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, pcen, alucontrol, illegal_op
    );
    modport slave (
        input  op, funct, zero, memready,
        output memwrite, irwrite, iord, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, pcen, alucontrol, illegal_op
    );
endinterface

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// ALU decoder: aluop + funct -> 3-bit ALU operation code.
// Latency: combinational.
// Backpressure: none. Ports: aluop_i, funct_i in; alucontrol_o out.
module alu_decoder
    import mips_pkg::*;
(
    input  aluop_t     aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o
);
    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB:   alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alucontrol_o = ALU_ADD;
                    FN_SUB:  alucontrol_o = ALU_SUB;
                    FN_AND:  alucontrol_o = ALU_AND;
                    FN_OR:   alucontrol_o = ALU_OR;
                    FN_SLT:  alucontrol_o = ALU_SLT;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default:     alucontrol_o = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback on a shared datapath.
// Latency: outputs registered with state; irwrite/pcen/illegal_op/alucontrol add input-qualified logic.
// Backpressure: memready=0 holds FETCH, MEMRD and MEMWR. Ports: clk, reset (async high), ctrl (slave bundle).
module mips_multicycle_controller
    import mips_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    mips_multicycle_controller_if.slave  ctrl
);
    state_t     state_q, state_d;
    ctrl_t      ctrl_q;
    logic [2:0] alucontrol_w;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (ctrl.memready) state_d = S_DECODE;
            S_DECODE: begin
                case (ctrl.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (ctrl.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (ctrl.memready) state_d = S_MEMWB;
            S_MEMWR:   if (ctrl.memready) state_d = S_FETCH;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Control word is decoded from the next state so it lines up with state_q
    // without a combinational path from state_q to the datapath strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    alu_decoder u_alu_dec (
        .aluop_i      (ctrl_q.aluop),
        .funct_i      (ctrl.funct),
        .alucontrol_o (alucontrol_w)
    );

    assign ctrl.memwrite   = ctrl_q.memwrite;
    assign ctrl.irwrite    = ctrl_q.irwrite_mr & ctrl.memready;
    assign ctrl.iord       = ctrl_q.iord;
    assign ctrl.regdst     = ctrl_q.regdst;
    assign ctrl.memtoreg   = ctrl_q.memtoreg;
    assign ctrl.regwrite   = ctrl_q.regwrite;
    assign ctrl.alusrca    = ctrl_q.alusrca;
    assign ctrl.alusrcb    = ctrl_q.alusrcb;
    assign ctrl.pcsrc      = ctrl_q.pcsrc;
    assign ctrl.pcen       = ctrl_q.pcwrite | (ctrl_q.pcwrite_mr & ctrl.memready) |
                             (ctrl_q.branch & ctrl.zero);
    assign ctrl.alucontrol = alucontrol_w;
    // Decode-stage only: the IR is valid from DECODE on, never during FETCH.
    assign ctrl.illegal_op = (state_q == S_DECODE) && !op_supported(ctrl.op);
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench for mips_multicycle_controller: per-cycle expected output vectors via a scoreboard queue.
// Latency: one check per clock, sampled on the falling edge.
// Backpressure: memready patterns exercise FETCH/MEMRD/MEMWR stalls.
module tb_mips_multicycle_controller;

    typedef struct packed {
        logic       memwrite;
        logic       irwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [2:0] alucontrol;
        logic       illegal_op;
    } obs_t;

    logic clk;
    logic reset;
    int   checks;
    int   passes;
    int   fails;
    obs_t exp_q[$];

    mips_multicycle_controller_if bus();

    mips_multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.memwrite = bus.memwrite;   o.irwrite = bus.irwrite;   o.iord = bus.iord;
        o.regdst = bus.regdst;       o.memtoreg = bus.memtoreg; o.regwrite = bus.regwrite;
        o.alusrca = bus.alusrca;     o.alusrcb = bus.alusrcb;   o.pcsrc = bus.pcsrc;
        o.pcen = bus.pcen;           o.alucontrol = bus.alucontrol;
        o.illegal_op = bus.illegal_op;
        return o;
    endfunction

    // Expected outputs for a named state, written straight from the state table.
    function automatic obs_t ex(input string st, input logic mr, input logic z, input logic [2:0] alu);
        obs_t o;
        o = '0;
        o.alucontrol = 3'b010;
        case (st)
            "FETCH":      begin o.alusrcb = 2'b01; o.irwrite = mr; o.pcen = mr; end
            "DECODE":     o.alusrcb = 2'b11;
            "DECODE_ILL": begin o.alusrcb = 2'b11; o.illegal_op = 1'b1; end
            "MEMADR",
            "ADDIEX":     begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            "MEMRD":      o.iord = 1'b1;
            "MEMWB":      begin o.regwrite = 1'b1; o.memtoreg = 1'b1; end
            "MEMWR":      begin o.iord = 1'b1; o.memwrite = 1'b1; end
            "RTYPEEX":    begin o.alusrca = 1'b1; o.alucontrol = alu; end
            "RTYPEWB":    begin o.regdst = 1'b1; o.regwrite = 1'b1; end
            "ADDIWB":     o.regwrite = 1'b1;
            "BEQEX":      begin o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = z; end
            "JEX":        begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
            default:      o = 'x;
        endcase
        return o;
    endfunction

    task automatic test_reset();
        obs_t got, e;
        bus.memready = 1'b0;
        exp_q.push_back(ex("FETCH", 1'b0, 1'b0, 3'b010));
        @(negedge clk);
        got = sample(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin fails++; $display("FAIL reset_mr0 got=%h exp=%h", got, e); end else passes++;
        bus.memready = 1'b1;
        exp_q.push_back(ex("FETCH", 1'b1, 1'b0, 3'b010));
        #1;
        got = sample(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin fails++; $display("FAIL reset_mr1 got=%h exp=%h", got, e); end else passes++;
        bus.memready = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw(input logic stall);
        string st[6];
        logic  mr[6];
        int    n;
        obs_t  got, e;
        bus.op = 6'b100011;
        if (stall) begin
            st = '{"FETCH", "DECODE", "MEMADR", "MEMRD", "MEMRD", "MEMWB"};
            mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
            n = 6;
        end else begin
            st = '{"FETCH", "DECODE", "MEMADR", "MEMRD", "MEMWB", ""};
            mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            n = 5;
        end
        for (int i = 0; i < n; i++) begin
            bus.memready = mr[i];
            exp_q.push_back(ex(st[i], mr[i], 1'b0, 3'b010));
            @(negedge clk);
            got = sample(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin fails++; $display("FAIL lw%0d[%0d] %s got=%h exp=%h", stall, i, st[i], got, e); end
            else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_stall();
        string st[7];
        logic  mr[7];
        obs_t  got, e;
        int    mw_cycles;
        st = '{"FETCH", "FETCH", "DECODE", "MEMADR", "MEMWR", "MEMWR", "MEMWR"};
        mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        bus.op = 6'b101011;
        mw_cycles = 0;
        for (int i = 0; i < 7; i++) begin
            bus.memready = mr[i];
            exp_q.push_back(ex(st[i], mr[i], 1'b0, 3'b010));
            @(negedge clk);
            got = sample(); e = exp_q.pop_front(); checks++;
            if (got.memwrite === 1'b1) mw_cycles++;
            if (got !== e) begin fails++; $display("FAIL sw[%0d] %s got=%h exp=%h", i, st[i], got, e); end
            else passes++;
            @(posedge clk); #1;
        end
        checks++;
        if (mw_cycles !== 3) begin fails++; $display("FAIL sw_memwrite_cycles got=%0d exp=3", mw_cycles); end
        else passes++;
    endtask

    task automatic test_rtype();
        logic [5:0] fn[5];
        logic [2:0] al[5];
        string      st[4];
        obs_t       got, e;
        fn = '{6'b101010, 6'b100010, 6'b111111, 6'b100100, 6'b100101};
        al = '{3'b111,    3'b110,    3'b010,    3'b000,    3'b001};
        st = '{"FETCH", "DECODE", "RTYPEEX", "RTYPEWB"};
        bus.op = 6'b000000;
        bus.memready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.funct = fn[k];
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back(ex(st[i], 1'b1, 1'b0, al[k]));
                @(negedge clk);
                got = sample(); e = exp_q.pop_front(); checks++;
                if (got !== e) begin fails++; $display("FAIL rtype_%b[%0d] %s got=%h exp=%h", fn[k], i, st[i], got, e); end
                else passes++;
                @(posedge clk); #1;
            end
        end
        bus.funct = 6'b000000;
    endtask

    task automatic test_beq();
        string st[3];
        obs_t  got, e;
        st = '{"FETCH", "DECODE", "BEQEX"};
        bus.op = 6'b000100;
        bus.memready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.zero = (k == 0);
            for (int i = 0; i < 3; i++) begin
                exp_q.push_back(ex(st[i], 1'b1, bus.zero, 3'b010));
                @(negedge clk);
                got = sample(); e = exp_q.pop_front(); checks++;
                if (got !== e) begin fails++; $display("FAIL beq_z%0d[%0d] %s got=%h exp=%h", bus.zero, i, st[i], got, e); end
                else passes++;
                @(posedge clk); #1;
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_back_to_back();
        string      st[7];
        logic [5:0] op[7];
        obs_t       got, e;
        st = '{"FETCH", "DECODE", "ADDIEX", "ADDIWB", "FETCH", "DECODE", "JEX"};
        op = '{6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b000010, 6'b000010, 6'b000010};
        bus.memready = 1'b1;
        bus.zero = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.op = op[i];
            exp_q.push_back(ex(st[i], 1'b1, 1'b1, 3'b010));
            @(negedge clk);
            got = sample(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin fails++; $display("FAIL b2b[%0d] %s got=%h exp=%h", i, st[i], got, e); end
            else passes++;
            @(posedge clk); #1;
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_illegal();
        string st[3];
        logic  mr[3];
        obs_t  got, e;
        st = '{"FETCH", "DECODE_ILL", "FETCH"};
        mr = '{1'b1, 1'b1, 1'b0};
        bus.op = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            bus.memready = mr[i];
            exp_q.push_back(ex(st[i], mr[i], 1'b0, 3'b010));
            @(negedge clk);
            got = sample(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin fails++; $display("FAIL illegal[%0d] %s got=%h exp=%h", i, st[i], got, e); end
            else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        string st[4];
        logic  mr[4];
        obs_t  got, e;
        st = '{"FETCH", "DECODE", "MEMADR", "MEMWR"};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0};
        bus.op = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            bus.memready = mr[i];
            exp_q.push_back(ex(st[i], mr[i], 1'b0, 3'b010));
            @(negedge clk);
            got = sample(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin fails++; $display("FAIL rstmid[%0d] %s got=%h exp=%h", i, st[i], got, e); end
            else passes++;
            if (i < 3) begin @(posedge clk); #1; end
        end
        // still in MEMWR, between edges: abort with reset
        #1 reset = 1'b1;
        exp_q.push_back(ex("FETCH", 1'b0, 1'b0, 3'b010));
        #1;
        got = sample(); e = exp_q.pop_front(); checks++;
        if (got.memwrite !== 1'b0) begin fails++; $display("FAIL rstmid_memwrite got=%b exp=0", got.memwrite); end
        else passes++;
        checks++;
        if (got !== e) begin fails++; $display("FAIL rstmid_fetch got=%h exp=%h", got, e); end else passes++;
        bus.memready = 1'b1;
        exp_q.push_back(ex("FETCH", 1'b1, 1'b0, 3'b010));
        #1;
        got = sample(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin fails++; $display("FAIL rstmid_fetch_mr1 got=%h exp=%h", got, e); end else passes++;
        @(posedge clk); #2;
        bus.memready = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(ex("FETCH", 1'b0, 1'b0, 3'b010));
        @(negedge clk);
        got = sample(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin fails++; $display("FAIL rstmid_release got=%h exp=%h", got, e); end else passes++;
        @(posedge clk); #1;
        // one full instruction after the abort proves normal sequencing resumed
        test_lw(1'b0);
    endtask

    initial begin
        checks = 0; passes = 0; fails = 0;
        reset = 1'b1;
        bus.op = 6'b000000; bus.funct = 6'b000000;
        bus.zero = 1'b0; bus.memready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_lw(1'b0);
        test_lw(1'b1);
        test_sw_stall();
        test_rtype();
        test_beq();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1);
    end

endmodule
